issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/cpu_configuration_pkg.sv | 19 +
 rtl/hazard_check.sv | 33 +++
 rtl/issue_scoreboard.sv | 134 +++++++++++++
 tb/tb_issue_scoreboard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_configuration_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_configuration (package)
//  Purpose  : Shared register-file sizing and issue-scoreboard FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_configuration;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } sb_state_e;

endpackage : cpu_configuration
`default_nettype wire

// File: rtl/hazard_check.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_check
//  Purpose  : Combinational RAW/WAW check of a decoded instruction against
//             the pending-write mask; x0 is never hazardous.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_check
  import cpu_configuration::*;
(
  input  logic [REG_COUNT-1:0] pending,
  input  logic [REG_AW-1:0]    rs1_ad,
  input  logic                 rs1_v,
  input  logic [REG_AW-1:0]    rs2_ad,
  input  logic                 rs2_v,
  input  logic [REG_AW-1:0]    rd_ad,
  input  logic                 rd_v,
  output logic                 hazard
);

  logic w_rs1_hz;
  logic w_rs2_hz;
  logic w_rd_hz;

  always_comb begin
    w_rs1_hz = rs1_v && (rs1_ad != '0) && pending[rs1_ad];
    w_rs2_hz = rs2_v && (rs2_ad != '0) && pending[rs2_ad];
    w_rd_hz  = rd_v  && (rd_ad  != '0) && pending[rd_ad];
    hazard   = w_rs1_hz || w_rs2_hz || w_rd_hz;
  end

endmodule : hazard_check
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard
//  Purpose  : In-order issue gate tracking outstanding register writes, with
//             hazard stall, in-flight limit, fence drain and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import cpu_configuration::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_AW-1:0]    dec_rs1_ad,
  input  logic [REG_AW-1:0]    dec_rs2_ad,
  input  logic                 dec_rs1_v,
  input  logic                 dec_rs2_v,
  input  logic [REG_AW-1:0]    dec_rd_ad,
  input  logic                 dec_rd_v,
  input  logic                 dec_fence,
  output logic                 dec_ready,
  input  logic                 iss_ready,
  output logic                 iss_valid,
  input  logic                 res_v,
  input  logic [REG_AW-1:0]    res_adr,
  input  logic                 flush,
  output logic [REG_COUNT-1:0] pending_o,
  output logic [2:0]           inflight_o,
  output logic                 busy
);

  localparam logic [2:0] C_MAX_INFLIGHT = 3'(MAX_INFLIGHT);

  sb_state_e            state_q,    state_d;
  logic [REG_COUNT-1:0] pending_q,  pending_d;
  logic [2:0]           inflight_q, inflight_d;

  logic w_hazard;
  logic w_tracked;
  logic w_limit_block;
  logic w_fence_block;
  logic w_set;
  logic w_retire;

  hazard_check u_hazard_check (
    .pending (pending_q),
    .rs1_ad  (dec_rs1_ad),
    .rs1_v   (dec_rs1_v),
    .rs2_ad  (dec_rs2_ad),
    .rs2_v   (dec_rs2_v),
    .rd_ad   (dec_rd_ad),
    .rd_v    (dec_rd_v),
    .hazard  (w_hazard)
  );

  // A fence only blocks while earlier writes are outstanding; with nothing in
  // flight it issues straight from RUN.
  always_comb begin
    w_tracked     = dec_rd_v && (dec_rd_ad != '0);
    w_limit_block = w_tracked && (inflight_q >= C_MAX_INFLIGHT);
    w_fence_block = dec_fence && (inflight_q != '0);
  end

  // Output logic
  always_comb begin
    dec_ready = !rst && (state_q == RUN) && !w_hazard && !flush && iss_ready
                && !w_limit_block && !w_fence_block;
    iss_valid = dec_valid && dec_ready;
    busy      = (inflight_q != '0) || (state_q != RUN);
  end

  // A retire only counts for a register actually pending, so stray or
  // post-reset writebacks can never underflow the counter.
  always_comb begin
    w_set      = iss_valid && w_tracked;
    w_retire   = res_v && (res_adr != '0) && pending_q[res_adr];
    pending_d  = pending_q;
    inflight_d = inflight_q;
    if (flush) begin
      pending_d  = '0;
      inflight_d = '0;
    end else begin
      if (w_retire) pending_d[res_adr]   = 1'b0;
      if (w_set)    pending_d[dec_rd_ad] = 1'b1;
      inflight_d = inflight_q + (w_set ? 3'd1 : 3'd0) - (w_retire ? 3'd1 : 3'd0);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (dec_valid && w_fence_block)
            state_d = DRAIN;
          else if (dec_valid && !dec_fence && (w_hazard || w_limit_block))
            state_d = STALL;
        end
        STALL: begin
          if (!dec_valid || !(w_hazard || w_limit_block))
            state_d = RUN;
        end
        DRAIN: begin
          if (!dec_valid || (inflight_q == '0))
            state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;

endmodule : issue_scoreboard
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scoreboard
//  Purpose  : Directed bench for issue_scoreboard with a per-cycle reference
//             model plus hand-computed spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

  localparam int MAX_INF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_rs1_ad, dec_rs2_ad, dec_rd_ad;
  logic        dec_rs1_v, dec_rs2_v, dec_rd_v, dec_fence;
  logic        dec_ready;
  logic        iss_ready;
  logic        iss_valid;
  logic        res_v;
  logic [4:0]  res_adr;
  logic        flush;
  logic [31:0] pending_o;
  logic [2:0]  inflight_o;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  issue_scoreboard #(.MAX_INFLIGHT(MAX_INF)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_rs1_ad (dec_rs1_ad),
    .dec_rs2_ad (dec_rs2_ad),
    .dec_rs1_v  (dec_rs1_v),
    .dec_rs2_v  (dec_rs2_v),
    .dec_rd_ad  (dec_rd_ad),
    .dec_rd_v   (dec_rd_v),
    .dec_fence  (dec_fence),
    .dec_ready  (dec_ready),
    .iss_ready  (iss_ready),
    .iss_valid  (iss_valid),
    .res_v      (res_v),
    .res_adr    (res_adr),
    .flush      (flush),
    .pending_o  (pending_o),
    .inflight_o (inflight_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: set of pending registers plus a "waiting" mode
  // (0 = evaluating, 1 = held on hazard/limit, 2 = draining for a fence).
  // The outstanding count is derived from the set, not kept separately.
  logic [31:0] mp = '0;
  int          mmode = 0;
  int          cnt;
  bit          hz, trk, lim, fblk, e_rdy, e_iv;

  always @(negedge clk) begin
    if (chk_en) begin
      cnt   = $countones(mp);
      hz    = (dec_rs1_v && dec_rs1_ad != 0 && mp[dec_rs1_ad]) ||
              (dec_rs2_v && dec_rs2_ad != 0 && mp[dec_rs2_ad]) ||
              (dec_rd_v  && dec_rd_ad  != 0 && mp[dec_rd_ad]);
      trk   = dec_rd_v && dec_rd_ad != 0;
      lim   = trk && cnt >= MAX_INF;
      fblk  = dec_fence && cnt != 0;
      e_rdy = !rst && mmode == 0 && !hz && !flush && iss_ready && !lim && !fblk;
      e_iv  = dec_valid && e_rdy;
      chk("dec_ready",  {31'b0, dec_ready},  {31'b0, e_rdy});
      chk("iss_valid",  {31'b0, iss_valid},  {31'b0, e_iv});
      chk("pending_o",  pending_o,           mp);
      chk("inflight_o", {29'b0, inflight_o}, 32'(cnt));
      chk("busy",       {31'b0, busy},       {31'b0, (cnt != 0 || mmode != 0)});
      if (rst || flush) begin
        mp    = '0;
        mmode = 0;
      end else begin
        case (mmode)
          0: if (dec_valid && fblk) mmode = 2;
             else if (dec_valid && !dec_fence && (hz || lim)) mmode = 1;
          1: if (!dec_valid || !(hz || lim)) mmode = 0;
          default: if (!dec_valid || cnt == 0) mmode = 0;
        endcase
        if (res_v && res_adr != 0) mp[res_adr] = 1'b0;
        if (e_iv && trk) mp[dec_rd_ad] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    res_v = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic r1v,
                         input logic [4:0] rs2, input logic r2v,
                         input logic [4:0] rd, input logic rdv, input logic fen);
    dec_valid  = v;
    dec_rs1_ad = rs1; dec_rs1_v = r1v;
    dec_rs2_ad = rs2; dec_rs2_v = r2v;
    dec_rd_ad  = rd;  dec_rd_v  = rdv;
    dec_fence  = fen;
  endtask

  task automatic wr(input logic [4:0] rd);
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0);
  endtask

  task automatic idle();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [4:0] a);
    res_v   = 1'b1;
    res_adr = a;
  endtask

  initial begin
    rst = 1'b1; iss_ready = 1'b1; res_v = 1'b0; res_adr = '0; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    wr(5'd1);
    #1;
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_inflight", {29'b0, inflight_o}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_no_issue", {31'b0, iss_valid}, 32'd0);
    tick();
    rst = 1'b0; idle(); tick();

    // RAW on x5
    wr(5'd5); #1 chk("raw_fire", {31'b0, iss_valid}, 32'd1); tick();
    set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 chk("raw_pend5_set", {31'b0, pending_o[5]}, 32'd1);
    chk("raw_stall", {31'b0, iss_valid}, 32'd0); tick();
    tick();
    ret(5'd5); #1 chk("raw_same_cycle_wb", {31'b0, iss_valid}, 32'd0); tick();
    #1 chk("raw_pend5_clr", {31'b0, pending_o[5]}, 32'd0);
    chk("raw_stall_exit", {31'b0, iss_valid}, 32'd0); tick();
    #1 chk("raw_issue", {31'b0, iss_valid}, 32'd1); tick();
    idle(); ret(5'd6); tick();

    // In-flight limit
    for (int i = 1; i <= 4; i++) begin
      wr(5'(i)); #1 chk("lim_fill", {31'b0, iss_valid}, 32'd1); tick();
    end
    wr(5'd5);
    #1 chk("lim_inflight4", {29'b0, inflight_o}, 32'd4);
    chk("lim_stall", {31'b0, iss_valid}, 32'd0); tick();
    ret(5'd1); #1 chk("lim_wb_cycle", {31'b0, iss_valid}, 32'd0); tick();
    #1 chk("lim_inflight3", {29'b0, inflight_o}, 32'd3); tick();
    #1 chk("lim_issue", {31'b0, iss_valid}, 32'd1); tick();
    idle(); dec_valid = 1'b1;
    #1 chk("lim_untracked", {31'b0, iss_valid}, 32'd1); tick();
    idle();
    for (int i = 2; i <= 5; i++) begin
      ret(5'(i)); tick();
    end

    // Fence drain
    wr(5'd10); tick();
    wr(5'd11); tick();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk("fence_block", {31'b0, iss_valid}, 32'd0); tick();
    ret(5'd10); #1 chk("fence_drain1", {31'b0, dec_ready}, 32'd0); tick();
    ret(5'd11); #1 chk("fence_drain2", {31'b0, dec_ready}, 32'd0); tick();
    #1 chk("fence_empty", {29'b0, inflight_o}, 32'd0);
    chk("fence_busy", {31'b0, busy}, 32'd1);
    chk("fence_hold", {31'b0, dec_ready}, 32'd0); tick();
    #1 chk("fence_issue", {31'b0, iss_valid}, 32'd1);
    chk("fence_issue_cnt", {29'b0, inflight_o}, 32'd0); tick();
    #1 chk("fence_direct", {31'b0, iss_valid}, 32'd1); tick();

    // Simultaneous fire and retire
    wr(5'd3); tick();
    wr(5'd7); ret(5'd3);
    #1 chk("sim_fire", {31'b0, iss_valid}, 32'd1); tick();
    idle();
    #1 chk("sim_inflight", {29'b0, inflight_o}, 32'd1);
    chk("sim_mask", pending_o, 32'h0000_0080);
    ret(5'd7); tick();

    // x0 destination and spurious writebacks
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); ret(5'd9);
    #1 chk("x0_fire", {31'b0, iss_valid}, 32'd1); tick();
    idle();
    #1 chk("x0_mask", pending_o, 32'h0);
    chk("x0_inflight", {29'b0, inflight_o}, 32'd0);
    ret(5'd0); tick();
    #1 chk("x0_no_underflow", {29'b0, inflight_o}, 32'd0);

    // Downstream back-pressure does not stall the FSM
    wr(5'd12); iss_ready = 1'b0;
    #1 chk("bp_hold", {31'b0, iss_valid}, 32'd0); tick();
    iss_ready = 1'b1;
    #1 chk("bp_release", {31'b0, iss_valid}, 32'd1); tick();
    idle(); ret(5'd12); tick();

    // dec_valid dropping in STALL
    wr(5'd13); tick();
    set_dec(1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    tick();
    idle(); #1 chk("stall_hold", {31'b0, dec_ready}, 32'd0); tick();
    #1 chk("stall_left", {31'b0, dec_ready}, 32'd1);
    ret(5'd13); tick();

    // Flush with three in flight
    wr(5'd1); tick();
    wr(5'd2); tick();
    wr(5'd3); tick();
    wr(5'd4); flush = 1'b1; ret(5'd1);
    #1 chk("flush_no_issue", {31'b0, iss_valid}, 32'd0); tick();
    #1 chk("flush_mask", pending_o, 32'h0);
    chk("flush_inflight", {29'b0, inflight_o}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_reissue", {31'b0, iss_valid}, 32'd1); tick();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); tick();
    flush = 1'b1; tick();
    #1 chk("flush_drain_exit", {31'b0, iss_valid}, 32'd1); tick();

    // Reset mid-operation, then a stale writeback
    wr(5'd8); tick();
    idle(); rst = 1'b1; ret(5'd8); tick();
    rst = 1'b0;
    #1 chk("rst_mid_mask", pending_o, 32'h0);
    ret(5'd8); tick();
    #1 chk("rst_stale_wb", {29'b0, inflight_o}, 32'd0);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_issue_scoreboard
`default_nettype wire
